// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: byte-serial RAM controller that arbitrates load/store traffic over instruction fetch.
// Optional macro IO_STALL_EN holds stores to the IO region while io_buffer_full is high.
module mem_ctrl_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_WIDTH = 8,
  parameter logic [1:0] IO_SEL_HI = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  ifetch_req,
  input  logic [ADDR_WIDTH-1:0] ifetch_addr,
  output logic                  ifetch_done,
  output logic [31:0]           ifetch_inst,
  input  logic                  lsb_req,
  input  logic                  lsb_we,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [1:0]            lsb_size,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata,
  input  logic                  flush,
  input  logic                  io_buffer_full,
  input  logic [RAM_WIDTH-1:0]  mem_din,
  output logic [RAM_WIDTH-1:0]  mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [1:0]            state_dbg
);
  // Handshake: a req is a level held until its done pulse; done is a single-cycle
  // pulse qualified by rdy, and the requester drops req on the edge ending that cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, IF_BUSY = 2'd1, LS_BUSY = 2'd2, DONE = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d, n_q, rd_off;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  we_q, fetch_q;
  logic [31:0]           wdata_q, data_q;
  logic                  ls_grantable, wr_stall, grant_ls, grant_if, capture;

  function automatic logic [2:0] size_n(input logic [1:0] size);
    case (size)
      2'd0:    size_n = 3'd1;
      2'd1:    size_n = 3'd2;
      default: size_n = 3'd4;
    endcase
  endfunction

`ifdef IO_STALL_EN
  logic io_q;
  assign ls_grantable = lsb_req && !(lsb_we && lsb_addr[17:16] == IO_SEL_HI && io_buffer_full);
  assign wr_stall = io_q && io_buffer_full;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) io_q <= 1'b0;
    else if (rdy && grant_ls) io_q <= lsb_we && lsb_addr[17:16] == IO_SEL_HI;
  end
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign ls_grantable = lsb_req;
  assign wr_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    capture  = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (ls_grantable) begin
            grant_ls = 1'b1;
            state_d  = LS_BUSY;
            cnt_d    = '0;
          end else if (ifetch_req && !flush) begin
            grant_if = 1'b1;
            state_d  = IF_BUSY;
            cnt_d    = '0;
          end
        end
        IF_BUSY: begin
          if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            capture = (cnt_q != 3'd0);
            if (cnt_q == n_q) state_d = DONE;
            else cnt_d = cnt_q + 3'd1;
          end
        end
        LS_BUSY: begin
          if (we_q) begin
            if (!wr_stall) begin
              if (cnt_q == n_q - 3'd1) state_d = DONE;
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            capture = (cnt_q != 3'd0);
            if (cnt_q == n_q) state_d = DONE;
            else cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // While frozen, a read re-presents the byte whose data is still outstanding, so the
  // RAM's one-cycle latency returns that byte again on the resume cycle.
  always_comb begin
    mem_a       = '0;
    mem_wr      = 1'b0;
    mem_dout    = '0;
    ifetch_done = 1'b0;
    lsb_done    = 1'b0;
    rd_off      = (!rdy && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    case (state_q)
      LS_BUSY: begin
        if (we_q) begin
          if (cnt_q < n_q) begin
            mem_a    = base_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
            mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: RAM_WIDTH];
            mem_wr   = rdy && !wr_stall;
          end
        end else if (cnt_q < n_q || !rdy) begin
          mem_a = base_q + {{(ADDR_WIDTH-3){1'b0}}, rd_off};
        end
      end
      IF_BUSY: begin
        if (cnt_q < n_q || !rdy) mem_a = base_q + {{(ADDR_WIDTH-3){1'b0}}, rd_off};
      end
      DONE: begin
        if (rdy) begin
          ifetch_done = fetch_q;
          lsb_done    = !fetch_q;
        end
      end
      default: ;
    endcase
  end

  assign byte_idx = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q  <= '0;
      n_q     <= '0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else if (rdy) begin
      if (grant_ls) begin
        base_q  <= lsb_addr;
        n_q     <= size_n(lsb_size);
        we_q    <= lsb_we;
        fetch_q <= 1'b0;
        wdata_q <= lsb_wdata;
        data_q  <= '0;
      end else if (grant_if) begin
        base_q  <= ifetch_addr;
        n_q     <= 3'd4;
        we_q    <= 1'b0;
        fetch_q <= 1'b1;
        data_q  <= '0;
      end
      if (capture) data_q[{byte_idx, 3'b000} +: RAM_WIDTH] <= mem_din;
    end
  end

  assign ifetch_inst = data_q;
  assign lsb_rdata   = data_q;
  assign state_dbg   = state_q;
endmodule
